// File: rtl/elastic_pipe_stage.sv
// rtl/elastic_pipe_stage.sv - one slot of the elastic pipeline: valid bit plus data register
module elastic_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             adv,
    input  logic             in_v,
    input  logic [WIDTH-1:0] in_d,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Data only loads with a real item so bubbles never toggle the register.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (adv) begin
            valid <= in_v;
            if (in_v) begin
                data <= in_d;
            end
        end
    end

endmodule

// File: rtl/elastic_pipe.sv
// rtl/elastic_pipe.sv - DEPTH-deep valid/ready register pipeline with flush and optional bubble collapsing
module elastic_pipe #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 2,
    parameter int COLLAPSE = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

    if (DEPTH < 1 || WIDTH < 1) begin : g_param_check
        $error("elastic_pipe: DEPTH and WIDTH must both be at least 1");
    end

    logic [DEPTH:0]   adv;
    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] stage_in_v;
    logic [WIDTH-1:0] stage_in_d [DEPTH];
    logic             in_fire;
    logic             out_fire;

    // Ready ripples from the output back to the input; in lockstep every stage shares one enable.
    always_comb begin
        adv        = '0;
        adv[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (COLLAPSE != 0) begin
                adv[i] = ~valid[i] | adv[i+1];
            end else begin
                adv[i] = adv[DEPTH] | ~valid[DEPTH-1];
            end
        end
    end

    assign in_ready  = adv[0] & ~flush;
    assign in_fire   = in_valid & in_ready;
    assign out_valid = valid[DEPTH-1] & ~flush;
    assign out_data  = data[DEPTH-1];
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        stage_in_v[0] = in_fire;
        stage_in_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            stage_in_v[i] = valid[i-1];
            stage_in_d[i] = data[i-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        elastic_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk  (clk),
            .reset(reset),
            .flush(flush),
            .adv  (adv[g]),
            .in_v (stage_in_v[g]),
            .in_d (stage_in_d[g]),
            .valid(valid[g]),
            .data (data[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            occupancy <= '0;
        end else if (in_fire && !out_fire) begin
            occupancy <= occupancy + OCC_ONE;
        end else if (!in_fire && out_fire) begin
            occupancy <= occupancy - OCC_ONE;
        end
    end

endmodule

// File: tb/tb_elastic_pipe.sv
// tb/tb_elastic_pipe.sv - self-checking bench for elastic_pipe in both collapse and lockstep modes
module tb_elastic_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, flush;
    logic       c_iv, c_ir, c_ov, c_or;
    logic [7:0] c_id, c_od;
    logic [1:0] c_occ;
    logic       l_iv, l_ir, l_ov, l_or;
    logic [7:0] l_id, l_od;
    logic [1:0] l_occ;

    int checks = 0;
    int bad = 0;
    bit mon_on = 1'b0;

    elastic_pipe #(.WIDTH(8), .DEPTH(3), .COLLAPSE(1)) dut_c (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
        .out_valid(c_ov), .out_ready(c_or), .out_data(c_od),
        .occupancy(c_occ)
    );

    elastic_pipe #(.WIDTH(8), .DEPTH(3), .COLLAPSE(0)) dut_l (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(l_iv), .in_ready(l_ir), .in_data(l_id),
        .out_valid(l_ov), .out_ready(l_or), .out_data(l_od),
        .occupancy(l_occ)
    );

    typedef struct packed {
        logic       rst;
        logic       fl;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic [1:0] e_occ;
    } vec_t;

    vec_t ctab[$];
    vec_t ltab[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input bit lock, input int idx);
        reset = v.rst;
        flush = v.fl;
        if (lock) begin
            l_iv = v.iv; l_id = v.id; l_or = v.ordy;
        end else begin
            c_iv = v.iv; c_id = v.id; c_or = v.ordy;
        end
        @(negedge clk);
        if (lock) begin
            check($sformatf("lock[%0d].in_ready", idx), {31'd0, l_ir}, {31'd0, v.e_ir});
            check($sformatf("lock[%0d].out_valid", idx), {31'd0, l_ov}, {31'd0, v.e_ov});
            check($sformatf("lock[%0d].out_data", idx), {24'd0, l_od}, {24'd0, v.e_od});
            check($sformatf("lock[%0d].occupancy", idx), {30'd0, l_occ}, {30'd0, v.e_occ});
        end else begin
            check($sformatf("coll[%0d].in_ready", idx), {31'd0, c_ir}, {31'd0, v.e_ir});
            check($sformatf("coll[%0d].out_valid", idx), {31'd0, c_ov}, {31'd0, v.e_ov});
            check($sformatf("coll[%0d].out_data", idx), {24'd0, c_od}, {24'd0, v.e_od});
            check($sformatf("coll[%0d].occupancy", idx), {30'd0, c_occ}, {30'd0, v.e_occ});
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: accepted items queued in order, compared as they leave.
    logic [7:0] cq[$];
    logic [7:0] lq[$];

    always @(negedge clk) begin
        if (mon_on) begin
            check("coll.occ_vs_model", {30'd0, c_occ}, cq.size());
            check("coll.in_ready_model", {31'd0, c_ir},
                  {31'd0, (!flush && (cq.size() < 3 || c_or))});
            if (reset || flush) begin
                cq.delete();
            end else begin
                if (c_ov && c_or) begin
                    if (cq.size() == 0) begin
                        checks++; bad++;
                        $display("FAIL coll.unexpected_out: got %0h expected none", c_od);
                    end else begin
                        check("coll.out_order", {24'd0, c_od}, {24'd0, cq.pop_front()});
                    end
                end
                if (c_iv && c_ir) cq.push_back(c_id);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            check("lock.occ_vs_model", {30'd0, l_occ}, lq.size());
            if (reset || flush) begin
                lq.delete();
            end else begin
                if (l_ov && l_or) begin
                    if (lq.size() == 0) begin
                        checks++; bad++;
                        $display("FAIL lock.unexpected_out: got %0h expected none", l_od);
                    end else begin
                        check("lock.out_order", {24'd0, l_od}, {24'd0, lq.pop_front()});
                    end
                end
                if (l_iv && l_ir) lq.push_back(l_id);
            end
        end
    end

    initial begin
        //                 rst   fl    iv    id     ordy  e_ir  e_ov  e_od   e_occ
        // reset held with 0xFF on the input
        ctab.push_back({1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0});
        ctab.push_back({1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0});
        ctab.push_back({1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0});
        // streaming
        ctab.push_back({1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0});
        ctab.push_back({1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00, 2'd1});
        ctab.push_back({1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 8'h00, 2'd2});
        ctab.push_back({1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 2'd3});
        ctab.push_back({1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 2'd2});
        ctab.push_back({1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 2'd1});
        // backpressure with a bubble, 0xA4 refused until out_ready rises
        ctab.push_back({1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h33, 2'd0});
        ctab.push_back({1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h33, 2'd1});
        ctab.push_back({1'b0, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 8'h33, 2'd1});
        ctab.push_back({1'b0, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 8'hA1, 2'd2});
        ctab.push_back({1'b0, 1'b0, 1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd3});
        ctab.push_back({1'b0, 1'b0, 1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd3});
        ctab.push_back({1'b0, 1'b0, 1'b1, 8'hA4, 1'b1, 1'b1, 1'b1, 8'hA1, 2'd3});
        ctab.push_back({1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA2, 2'd3});
        ctab.push_back({1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3, 2'd2});
        ctab.push_back({1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA4, 2'd1});
        // flush with two items held and 0x55 offered
        ctab.push_back({1'b0, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b1, 1'b0, 8'hA4, 2'd0});
        ctab.push_back({1'b0, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b1, 1'b0, 8'hA4, 2'd1});
        ctab.push_back({1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA4, 2'd2});
        ctab.push_back({1'b0, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 8'hB1, 2'd2});
        ctab.push_back({1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hB1, 2'd0});
        // fill, then simultaneous push/pop at full
        ctab.push_back({1'b0, 1'b0, 1'b1, 8'hC1, 1'b0, 1'b1, 1'b0, 8'hB1, 2'd0});
        ctab.push_back({1'b0, 1'b0, 1'b1, 8'hC2, 1'b0, 1'b1, 1'b0, 8'hB1, 2'd1});
        ctab.push_back({1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 8'hB1, 2'd2});
        ctab.push_back({1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 8'hC1, 2'd3});
        ctab.push_back({1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 8'hC2, 2'd3});
        ctab.push_back({1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 8'hC3, 2'd3});
        ctab.push_back({1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 8'h77, 2'd3});
        ctab.push_back({1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h77, 2'd3});
        ctab.push_back({1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h77, 2'd2});
        ctab.push_back({1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h77, 2'd1});
        ctab.push_back({1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h77, 2'd0});
        // reset mid-transfer clears data too
        ctab.push_back({1'b1, 1'b0, 1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 8'h77, 2'd0});
        ctab.push_back({1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0});

        // lockstep: bubble retained while frozen, 0xA3 waits for the advance
        ltab.push_back({1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0});
        ltab.push_back({1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1});
        ltab.push_back({1'b0, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1});
        ltab.push_back({1'b0, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd2});
        ltab.push_back({1'b0, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd2});
        ltab.push_back({1'b0, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA1, 2'd2});
        ltab.push_back({1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA1, 2'd2});
        ltab.push_back({1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA2, 2'd2});
        ltab.push_back({1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3, 2'd1});
        ltab.push_back({1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA3, 2'd0});

        reset = 1'b1; flush = 1'b0;
        c_iv = 1'b0; c_id = 8'h00; c_or = 1'b1;
        l_iv = 1'b0; l_id = 8'h00; l_or = 1'b1;
        @(posedge clk);
        #1;
        mon_on = 1'b1;

        for (int i = 0; i < ctab.size(); i++) apply(ctab[i], 1'b0, i);
        c_iv = 1'b0; c_or = 1'b1;
        for (int i = 0; i < ltab.size(); i++) apply(ltab[i], 1'b1, i);

        l_iv = 1'b0; l_or = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("coll.drained", cq.size(), 0);
        check("lock.drained", lq.size(), 0);

        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end

endmodule
